input_debouncer: RTL and testbench

Multi-channel synchronizer and debouncer for raw asynchronous front-panel inputs (buttons, switches, key contacts). Each channel is brought into the `mclk` domain through a two-flop synchronizer. The synchronized value is qualified by a per-channel stability counter driven from a shared sample-tick prescaler. The block sits directly upstream of the edge detectors: each `level` bit drives an edge detector's `signal` input, and `changed` is available to blocks that need a toggle strobe only.

---
 rtl/input_debouncer.sv | 108 ++++++++++
 tb/tb_input_debouncer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Multi-channel two-flop synchronizer and tick-qualified debouncer.
// Each channel accepts a new level after STABLE_TICKS differing ticks.
module input_debouncer #(
    parameter int   WIDTH        = 4,
    parameter int   CLK_DIV      = 1000,
    parameter int   STABLE_TICKS = 16,
    parameter logic INIT_VALUE   = 1'b0
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] changed,
    output logic             tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(STABLE_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] sync;
    logic [DIV_W-1:0] div_cnt;

    // Two-flop synchronizer bringing raw contacts into the mclk domain
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= {WIDTH{INIT_VALUE}};
            sync <= {WIDTH{INIT_VALUE}};
        end else begin
            s1   <= raw;
            sync <= s1;
        end
    end

    // Shared prescaler producing one sample tick every CLK_DIV cycles
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             lvl;
        logic             chg;

        // Per-channel stability FSM; level only moves after a full run
        always_ff @(posedge mclk or negedge rst_n) begin
            if (!rst_n) begin
                state <= IDLE;
                cnt   <= '0;
                lvl   <= INIT_VALUE;
                chg   <= 1'b0;
            end else begin
                chg <= 1'b0;
                if (tick) begin
                    unique case (state)
                        IDLE: begin
                            if (sync[i] != lvl) begin
                                if (STABLE_TICKS == 1) begin
                                    lvl <= sync[i];
                                    chg <= 1'b1;
                                    cnt <= '0;
                                end else begin
                                    cnt   <= CNT_W'(1);
                                    state <= COUNT;
                                end
                            end else begin
                                cnt <= '0;
                            end
                        end
                        COUNT: begin
                            if (sync[i] == lvl) begin
                                cnt   <= '0;
                                state <= IDLE;
                            end else if (cnt == CNT_LAST) begin
                                lvl   <= sync[i];
                                chg   <= 1'b1;
                                cnt   <= '0;
                                state <= IDLE;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    endcase
                end
            end
        end

        assign level[i]   = lvl;
        assign changed[i] = chg;
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer across several parameter sets.
// Expected values are queued at stimulus time and popped on check.
module tb_input_debouncer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
    logic       rst_d = 1'b0, rst_e = 1'b0;
    logic [3:0] raw_a = '0, raw_b = '0, raw_c = '0, raw_d = '0, raw_e = '0;
    logic [3:0] level_a, level_b, level_c, level_d, level_e;
    logic [3:0] changed_a, changed_b, changed_c, changed_d, changed_e;
    logic       tick_a, tick_b, tick_c, tick_d, tick_e;

    input_debouncer #(.CLK_DIV(1), .STABLE_TICKS(3)) u_a (
        .mclk(clk), .rst_n(rst_a), .raw(raw_a),
        .level(level_a), .changed(changed_a), .tick(tick_a));
    input_debouncer #(.CLK_DIV(4), .STABLE_TICKS(3)) u_b (
        .mclk(clk), .rst_n(rst_b), .raw(raw_b),
        .level(level_b), .changed(changed_b), .tick(tick_b));
    input_debouncer #(.CLK_DIV(1), .STABLE_TICKS(8)) u_c (
        .mclk(clk), .rst_n(rst_c), .raw(raw_c),
        .level(level_c), .changed(changed_c), .tick(tick_c));
    input_debouncer #(.CLK_DIV(2), .STABLE_TICKS(3)) u_d (
        .mclk(clk), .rst_n(rst_d), .raw(raw_d),
        .level(level_d), .changed(changed_d), .tick(tick_d));
    input_debouncer #(.CLK_DIV(5), .STABLE_TICKS(16)) u_e (
        .mclk(clk), .rst_n(rst_e), .raw(raw_e),
        .level(level_e), .changed(changed_e), .tick(tick_e));

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %0h required nothing", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int       pulses;
    int       nz;
    logic [3:0] cap;

    initial begin
        // reset values while held in reset
        cyc(2);
        expect_val("rst_level_e", 32'h0);   check(32'(level_e));
        expect_val("rst_changed_e", 32'h0); check(32'(changed_e));
        expect_val("rst_tick_e", 32'h0);    check(32'(tick_e));
        expect_val("rst_level_a", 32'h0);   check(32'(level_a));

        // tick cadence CLK_DIV=5, first tick sampled by edge 5
        rst_e = 1'b1;
        rst_a = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            expect_val($sformatf("tick_e_edge%0d", n), 32'((n % 5) == 0));
            check(32'(tick_e));
            cyc(1);
        end
        expect_val("tick_a_const", 32'h1); check(32'(tick_a));
        expect_val("idle_changed_e", 32'h0); check(32'(changed_e));

        // clean step latency CLK_DIV=1 STABLE_TICKS=3
        raw_a = 4'b0001;
        cyc(4);
        expect_val("step_level_e4", 32'h0);   check(32'(level_a));
        expect_val("step_changed_e4", 32'h0); check(32'(changed_a));
        cyc(1);
        expect_val("step_level_e5", 32'h1);   check(32'(level_a));
        expect_val("step_changed_e5", 32'h1); check(32'(changed_a));
        cyc(1);
        expect_val("step_changed_e6", 32'h0); check(32'(changed_a));
        expect_val("step_level_e6", 32'h1);   check(32'(level_a));
        expect_val("tick_a_run", 32'h1);      check(32'(tick_a));

        // bounce rejection CLK_DIV=4 STABLE_TICKS=3
        rst_b = 1'b1;
        cyc(2);
        raw_b = 4'b0010;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            if (changed_b != 4'b0) pulses++;
        end
        raw_b = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            cyc(1);
            if (changed_b != 4'b0) pulses++;
        end
        expect_val("bounce_pulses", 32'h0); check(32'(pulses));
        expect_val("bounce_level", 32'h0);  check(32'(level_b));
        raw_b = 4'b0010;
        pulses = 0;
        for (int k = 0; k < 24; k++) begin
            cyc(1);
            if (changed_b[1]) pulses++;
            if (changed_b[0] || changed_b[3:2] != 2'b0) pulses += 100;
        end
        expect_val("hold_pulses", 32'h1);  check(32'(pulses));
        expect_val("hold_level", 32'h2);   check(32'(level_b));

        // abort by reset CLK_DIV=1 STABLE_TICKS=8
        rst_c = 1'b1;
        raw_c = 4'b0100;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            if (changed_c != 4'b0) pulses++;
        end
        expect_val("abort_pre_pulses", 32'h0); check(32'(pulses));
        rst_c = 1'b0;
        #2;
        expect_val("abort_level", 32'h0);   check(32'(level_c));
        expect_val("abort_changed", 32'h0); check(32'(changed_c));
        cyc(1);
        rst_c = 1'b1;
        cyc(9);
        expect_val("abort_level_e9", 32'h0);  check(32'(level_c));
        cyc(1);
        expect_val("abort_level_e10", 32'h4);   check(32'(level_c));
        expect_val("abort_changed_e10", 32'h4); check(32'(changed_c));

        // simultaneous channels CLK_DIV=2
        rst_d = 1'b1;
        cyc(3);
        raw_d = 4'b0101;
        nz = 0;
        cap = '0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            if (changed_d != 4'b0) begin
                nz++;
                cap = changed_d;
            end
        end
        expect_val("simul_rise_cycles", 32'h1);  check(32'(nz));
        expect_val("simul_rise_changed", 32'h5); check(32'(cap));
        expect_val("simul_rise_level", 32'h5);   check(32'(level_d));
        raw_d = 4'b0000;
        nz = 0;
        cap = '0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            if (changed_d != 4'b0) begin
                nz++;
                cap = changed_d;
            end
        end
        expect_val("simul_fall_cycles", 32'h1);  check(32'(nz));
        expect_val("simul_fall_changed", 32'h5); check(32'(cap));
        expect_val("simul_fall_level", 32'h0);   check(32'(level_d));

        // asynchronous reset with all levels high
        raw_d = 4'b1111;
        cyc(20);
        expect_val("all_high_level", 32'hf); check(32'(level_d));
        #2;
        rst_d = 1'b0;
        #1;
        expect_val("async_rst_level", 32'h0);   check(32'(level_d));
        expect_val("async_rst_changed", 32'h0); check(32'(changed_d));

        expect_val("scoreboard_drained", 32'h0); check(32'(sb.size() - 1));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
